// File: rtl/binary_to_rns_if.sv
// Handshake bundle between an operand producer, the binary-to-RNS forward
// converter and the consumer of packed residue words.
interface binary_to_rns_if #(
    parameter int BIN_W = 9,
    parameter int RES_W = 3
);
    // operand side
    logic               in_valid;
    logic               in_ready;
    logic [BIN_W-1:0]   bin;
    // result side
    logic               out_valid;
    logic               out_ready;
    logic [3*RES_W-1:0] rns;
    logic               overflow;

    // converter view
    modport slave (
        input  in_valid,
        input  bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output rns,
        output overflow
    );

    // producer/consumer view
    modport master (
        output in_valid,
        output bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  rns,
        input  overflow
    );
endinterface

// File: rtl/binary_to_rns.sv
// Iterative binary -> RNS forward converter for moduli (M0,M1,M2).
// Consumes one operand bit per cycle, MSB first, updating every residue with
// r = 2r + b reduced by a single conditional subtract. Result is packed as
// {r(M0), r(M1), r(M2)} to match the downstream RNS-to-binary converter.
module binary_to_rns #(
    parameter int BIN_W = 9,
    parameter int RES_W = 3,
    parameter int M0    = 8,
    parameter int M1    = 7,
    parameter int M2    = 5,
    parameter int N     = 280
) (
    input  logic           clock,
    input  logic           reset,
    binary_to_rns_if.slave bus
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [BIN_W-1:0]          shift_q, shift_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    // index 0 holds the M0 residue, index 2 the M2 residue
    logic [2:0][RES_W-1:0]     res_q, res_d, res_step;
    logic                      cur_bit;

    // operand bits are consumed from the top of the shift register
    assign cur_bit = shift_q[BIN_W-1];

    // one doubling-and-reduce step per modulus; since r < M, 2r+b < 2M so a
    // single subtract is enough, and a power-of-two modulus needs no special case
    for (genvar gi = 0; gi < 3; gi++) begin : g_res
        localparam int MI = (gi == 0) ? M0 : ((gi == 1) ? M1 : M2);
        localparam logic [RES_W:0] MOD = (RES_W+1)'(MI);
        logic [RES_W:0] t;
        logic [RES_W:0] t_sub;
        assign t           = {res_q[gi], cur_bit};
        assign t_sub       = t - MOD;
        assign res_step[gi] = (t >= MOD) ? t_sub[RES_W-1:0] : t[RES_W-1:0];
    end

    // state and datapath registers; async reset discards any conversion in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
        end
    end

    // next-state and datapath update
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = CONV;
                    shift_d = bus.bin;
                    cnt_d   = CNT_W'(BIN_W - 1);
                    res_d   = '0;
                    // residues stay exact above N, they just stop being unique
                    ovf_d   = (32'(bus.bin) >= 32'(N));
                end
            end
            CONV: begin
                res_d   = res_step;
                shift_d = shift_q << 1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.rns       = {res_q[0], res_q[1], res_q[2]};
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_binary_to_rns.sv
// Directed bench for the binary -> RNS converter: known vectors, overflow,
// backpressure, mid-conversion reset and a full-range round trip through a
// CRT reconstruction model.
module tb_binary_to_rns;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    binary_to_rns_if #(.BIN_W(9), .RES_W(3)) bus ();

    binary_to_rns #(
        .BIN_W(9), .RES_W(3), .M0(8), .M1(7), .M2(5), .N(280)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference RNS-to-binary: search the dynamic range for the matching residues
    function automatic int crt(input int a, input int b, input int c);
        for (int x = 0; x < 280; x++) begin
            if ((x % 8) == a && (x % 7) == b && (x % 5) == c) return x;
        end
        return -1;
    endfunction

    // one full transaction: accept, wait (bounded) for result, check, drain
    task automatic run_op(input logic [8:0] v, input logic [8:0] exp_rns,
                          input logic exp_ovf, input bit hold_ready,
                          input string tag, output logic [8:0] got_rns);
        int n;
        @(negedge clock);
        check({tag, " in_ready idle"}, 32'(bus.in_ready), 1);
        bus.out_ready = hold_ready;
        bus.in_valid  = 1'b1;
        bus.bin       = v;
        @(negedge clock);
        bus.in_valid  = 1'b0;
        bus.bin       = 9'($urandom);
        check({tag, " in_ready conv"}, 32'(bus.in_ready), 0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, " latency"}, n, 9);
        check({tag, " rns"}, 32'(bus.rns), 32'(exp_rns));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        got_rns = bus.rns;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check({tag, " out_valid drop"}, 32'(bus.out_valid), 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] got;
        int         n;
        int         highs;

        bus.in_valid  = 1'b0;
        bus.bin       = '0;
        bus.out_ready = 1'b0;

        // reset state
        #2;
        check("reset out_valid", 32'(bus.out_valid), 0);
        check("reset rns", 32'(bus.rns), 0);
        check("reset overflow", 32'(bus.overflow), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post-reset in_ready", 32'(bus.in_ready), 1);
        check("post-reset out_valid", 32'(bus.out_valid), 0);

        // directed vectors
        run_op(9'd123, 9'b011_100_011, 1'b0, 1'b0, "bin123", got);
        run_op(9'd78,  9'b110_001_011, 1'b0, 1'b0, "bin78",  got);
        run_op(9'd3,   9'b011_011_011, 1'b0, 1'b0, "bin3",   got);
        run_op(9'd0,   9'b000_000_000, 1'b0, 1'b0, "bin0",   got);
        run_op(9'd279, 9'b111_110_100, 1'b0, 1'b0, "bin279", got);
        run_op(9'd300, 9'b100_110_000, 1'b1, 1'b0, "bin300", got);
        run_op(9'd511, 9'b111_000_001, 1'b1, 1'b0, "bin511", got);
        run_op(9'd280, 9'b000_000_000, 1'b1, 1'b0, "bin280", got);

        // backpressure: result held for 20 cycles, new operands ignored
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.bin      = 9'd78;
        @(negedge clock);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("bp latency", n, 9);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.bin      = 9'(i * 7 + 1);
            check("bp out_valid", 32'(bus.out_valid), 1);
            check("bp rns", 32'(bus.rns), 32'(9'b110_001_011));
            check("bp in_ready", 32'(bus.in_ready), 0);
            @(negedge clock);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("bp release out_valid", 32'(bus.out_valid), 0);
        check("bp release in_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b0;
        highs = 0;
        repeat (12) begin
            @(negedge clock);
            if (bus.out_valid === 1'b1) highs++;
        end
        check("bp ignored operand", highs, 0);

        // reset in the middle of converting 200
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.bin      = 9'd200;
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midreset out_valid", 32'(bus.out_valid), 0);
        check("midreset rns", 32'(bus.rns), 0);
        @(negedge clock);
        reset = 1'b1;
        highs = 0;
        repeat (15) begin
            @(negedge clock);
            if (bus.out_valid === 1'b1) highs++;
        end
        check("midreset no pulse", highs, 0);
        check("midreset in_ready", 32'(bus.in_ready), 1);
        run_op(9'd45, 9'b101_011_000, 1'b0, 1'b0, "bin45", got);

        // full-range round trip, out_ready held high throughout
        for (int v = 0; v < 280; v++) begin
            run_op(9'(v), {3'(v % 8), 3'(v % 7), 3'(v % 5)}, 1'b0, 1'b1,
                   $sformatf("sweep%0d", v), got);
            check($sformatf("sweep%0d roundtrip", v),
                  32'(crt(int'(got[8:6]), int'(got[5:3]), int'(got[2:0]))), 32'(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
